exe_stage: RTL and testbench

Execute stage of the 8-bit teaching pipeline. It is the consumer of the decode-stage output bus: it latches the decoded bundle (one-hot op, ry value, rx value, immediate) and performs the ALU operation. It presents the result to the writeback stage over a valid/allowin handshake. Single-cycle ops add one cycle of latency; MUL is an iterative shift-add over DATA_W cycles that back-pressures decode.

---
 rtl/exe_stage.sv | 174 +++++++++++++++++
 tb/tb_exe_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage -- execute stage of the 8-bit teaching pipeline.
//
// Latches one decoded bundle from decode (one-hot op, ry, rx, imm, dest),
// performs the ALU operation and hands the result to writeback.
// ADD/SUB/ADDI/illegal ops finish in one cycle. MUL is an iterative
// shift-add that takes DATA_W cycles and back-pressures decode while busy.
//
// Handshake (both sides): a bundle moves across a stage boundary on a rising
// clk edge exactly when the producer's valid and the consumer's allowin are
// both high at that edge. The producer keeps its bundle stable while valid is
// high and allowin is low. Allowin never depends on the producer's valid.
//
// Ports:
//   clk             pipeline clock, rising edge
//   reset           asynchronous, active-high reset
//   ds_to_es_valid  decode bundle valid
//   ds_to_es_bus    [4+3W-1 -: 4] one-hot op, then ry, rx, imm (W bits each)
//   ds_to_es_dest   destination register index, sideband to the bus
//   es_allowin      stage can accept a bundle this cycle
//   es_to_ws_valid  result bundle valid
//   es_to_ws_bus    [W+4] we, [W+3] zero, [W+2] carry, [W+1:W] dest, [W-1:0] result
//   ws_allowin      writeback can accept this cycle
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ds_to_es_valid,
  input  logic [4+3*DATA_W-1:0] ds_to_es_bus,
  input  logic [1:0]            ds_to_es_dest,
  output logic                  es_allowin,
  output logic                  es_to_ws_valid,
  output logic [DATA_W+4:0]     es_to_ws_bus,
  input  logic                  ws_allowin
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0001;

  // Multiplier sequencer state; kept as a named signal so checkers can bind.
  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  mul_state_t          mul_state;
  logic                es_valid;
  logic [3:0]          op_r;
  logic [DATA_W-1:0]   ry_r;
  logic [DATA_W-1:0]   rx_r;
  logic [DATA_W-1:0]   imm_r;
  logic [1:0]          dest_r;
  logic [CNT_W-1:0]    mul_cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;

  logic [3:0]          in_op;
  logic [DATA_W-1:0]   in_ry;
  logic [DATA_W-1:0]   in_rx;
  logic [DATA_W-1:0]   in_imm;

  logic                es_ready_go;
  logic                accept;
  logic                drain;

  assign in_op  = ds_to_es_bus[4+3*DATA_W-1 -: 4];
  assign in_ry  = ds_to_es_bus[3*DATA_W-1 -: DATA_W];
  assign in_rx  = ds_to_es_bus[2*DATA_W-1 -: DATA_W];
  assign in_imm = ds_to_es_bus[DATA_W-1:0];

  assign es_ready_go    = (mul_cnt == '0);
  assign es_allowin     = !es_valid || (es_ready_go && ws_allowin);
  assign es_to_ws_valid = es_valid && es_ready_go;
  assign accept         = ds_to_es_valid && es_allowin;
  assign drain          = es_to_ws_valid && ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid  <= 1'b0;
      op_r      <= '0;
      ry_r      <= '0;
      rx_r      <= '0;
      imm_r     <= '0;
      dest_r    <= '0;
      mul_cnt   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      mul_state <= MUL_IDLE;
    end else begin
      if (accept) begin
        es_valid <= 1'b1;
        op_r     <= in_op;
        ry_r     <= in_ry;
        rx_r     <= in_rx;
        imm_r    <= in_imm;
        dest_r   <= ds_to_es_dest;
        if (in_op == OP_MUL) begin
          mul_cnt   <= MUL_ITERS;
          acc       <= '0;
          mcand     <= {{DATA_W{1'b0}}, in_rx};
          mplier    <= in_ry;
          mul_state <= MUL_BUSY;
        end
      end else if (drain) begin
        es_valid <= 1'b0;
      end

      // Accept cannot coincide with BUSY: es_valid is set and ready_go is low.
      if (mul_state == MUL_BUSY) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt - CNT_ONE;
        if (mul_cnt == CNT_ONE) begin
          mul_state <= MUL_IDLE;
        end
      end
    end
  end

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              zero;
  logic              we;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    we     = 1'b1;
    case (op_r)
      OP_ADD: begin
        sum    = {1'b0, rx_r} + {1'b0, ry_r};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = rx_r - ry_r;
        carry  = (rx_r < ry_r);
      end
      OP_ADDI: begin
        sum    = {1'b0, rx_r} + {1'b0, imm_r};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_MUL: begin
        result = acc[DATA_W-1:0];
        carry  = |acc[2*DATA_W-1:DATA_W];
      end
      // Zero or multi-hot op: flows through as a non-writing bubble.
      default: begin
        we = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

  // Bus reads as zero whenever nothing is being offered to writeback.
  assign es_to_ws_bus = es_to_ws_valid ? {we, zero, carry, dest_r, result} : '0;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage -- self-checking bench for exe_stage (DATA_W = 8).
// Driver tasks push the hand-computed result bundle into exp_q when decode's
// bundle is accepted; a monitor on the falling edge pops and compares each
// bundle that transfers to writeback on the following rising edge.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  logic        clk;
  logic        reset;
  logic        ds_to_es_valid;
  logic [27:0] ds_to_es_bus;
  logic [1:0]  ds_to_es_dest;
  logic        es_allowin;
  logic        es_to_ws_valid;
  logic [12:0] es_to_ws_bus;
  logic        ws_allowin;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  exe_stage #(.DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .ds_to_es_dest  (ds_to_es_dest),
    .es_allowin     (es_allowin),
    .es_to_ws_valid (es_to_ws_valid),
    .es_to_ws_bus   (es_to_ws_bus),
    .ws_allowin     (ws_allowin)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [12:0] mk(input logic we, input logic zero, input logic carry,
                                     input logic [1:0] dest, input logic [7:0] res);
    return {we, zero, carry, dest, res};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge. Presents the bundle, waits (bounded) for
  // es_allowin, records the expected result, and returns just after the
  // accept edge with ds_to_es_valid dropped.
  task automatic send(input logic [3:0] op, input logic [7:0] rx, input logic [7:0] ry,
                      input logic [7:0] imm, input logic [1:0] dest,
                      input logic [12:0] exp, output int waited);
    waited = 0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = {op, ry, rx, imm};
    ds_to_es_dest  = dest;
    @(negedge clk);
    while (!es_allowin && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!es_allowin) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: es_allowin=%0b expected 1 within 40 cycles", es_allowin);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = $urandom_range(0, 32'h0FFF_FFFF);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && es_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got bundle 0x%0h expected none", es_to_ws_bus);
      end else begin
        check("result_bundle", {19'd0, es_to_ws_bus}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    reset          = 1'b1;
    ws_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ds_to_es_dest  = '0;

    #2;
    check("reset_valid",   {31'd0, es_to_ws_valid}, 32'd0);
    check("reset_bus",     {19'd0, es_to_ws_bus},   32'd0);
    check("reset_allowin", {31'd0, es_allowin},     32'd1);

    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD 3+5, single-cycle pulse (a second pulse would be an unexpected output)
    send(4'b1000, 8'h03, 8'h05, 8'h77, 2'd2, mk(1, 0, 0, 2'd2, 8'h08), w);
    check("add_wait", w, 0);
    repeat (2) @(posedge clk);
    #1;

    // SUB borrow then ADDI overflow, back to back
    send(4'b0100, 8'h03, 8'h05, 8'h00, 2'd1, mk(1, 0, 1, 2'd1, 8'hFE), w);
    check("sub_wait", w, 0);
    send(4'b0010, 8'hF0, 8'h33, 8'h10, 2'd3, mk(1, 1, 1, 2'd3, 8'h00), w);
    check("addi_b2b_wait", w, 0);
    repeat (2) @(posedge clk);
    #1;

    // MUL 0x12*0x34 = 0x03A8; next ADD must wait out 8 busy cycles
    send(4'b0001, 8'h12, 8'h34, 8'h00, 2'd0, mk(1, 0, 1, 2'd0, 8'hA8), w);
    check("mul_wait", w, 0);
    send(4'b1000, 8'h01, 8'hFF, 8'h00, 2'd1, mk(1, 1, 1, 2'd1, 8'h00), w);
    check("busy_stall_cycles", w, 8);
    repeat (2) @(posedge clk);
    #1;

    // More MUL patterns: no high bits, and all ones
    send(4'b0001, 8'h0F, 8'h0E, 8'h00, 2'd2, mk(1, 0, 0, 2'd2, 8'hD2), w);
    send(4'b0001, 8'hFF, 8'hFF, 8'h00, 2'd3, mk(1, 0, 1, 2'd3, 8'h01), w);
    check("mul_b2b_stall", w, 8);
    repeat (10) @(posedge clk);
    #1;

    // Back-pressure: ADD result held for 3 cycles, queued SUB accepted on transfer edge
    ws_allowin = 1'b0;
    send(4'b1000, 8'h40, 8'h40, 8'h00, 2'd2, mk(1, 0, 0, 2'd2, 8'h80), w);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = {4'b0100, 8'h10, 8'h10, 8'h00};
    ds_to_es_dest  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid",   {31'd0, es_to_ws_valid}, 32'd1);
      check("bp_bus",     {19'd0, es_to_ws_bus},   {19'd0, mk(1, 0, 0, 2'd2, 8'h80)});
      check("bp_allowin", {31'd0, es_allowin},     32'd0);
      @(posedge clk);
      #1;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    check("bp_release_allowin", {31'd0, es_allowin}, 32'd1);
    if (es_allowin) exp_q.push_back(mk(1, 1, 0, 2'd0, 8'h00));
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Illegal ops: 0000 and multi-hot 1100
    send(4'b0000, 8'h12, 8'h34, 8'h56, 2'd3, mk(0, 1, 0, 2'd3, 8'h00), w);
    check("illegal0_wait", w, 0);
    send(4'b1100, 8'hFF, 8'hFF, 8'hFF, 2'd1, mk(0, 1, 0, 2'd1, 8'h00), w);
    check("illegal_mh_wait", w, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during MUL after 4 iterations, asserted between edges
    send(4'b0001, 8'h12, 8'h34, 8'h00, 2'd1, mk(1, 0, 1, 2'd1, 8'hA8), w);
    repeat (4) @(posedge clk);
    #2;
    check("mul_busy_before_reset", {31'd0, es_allowin}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_valid",   {31'd0, es_to_ws_valid}, 32'd0);
    check("midreset_allowin", {31'd0, es_allowin},     32'd1);
    check("midreset_bus",     {19'd0, es_to_ws_bus},   32'd0);
    // The discarded product must never appear.
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // One more ADD after reset to show the stage recovers
    send(4'b1000, 8'h7F, 8'h01, 8'h00, 2'd0, mk(1, 0, 0, 2'd0, 8'h80), w);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
